ratio_clk_meter: RTL and testbench

- Downstream monitor for the ratio-driven clock output.
- Samples the divided clock in the clk_i domain and detects its rising edges.
- Measures period and high time in clk_i cycles and compares the period against a programmed expected value.
- Raises a lock flag after enough consecutive matches. Used for self-checking in test benches and as a runtime health monitor next to ratio_clk.

---
 rtl/ratio_clk_pkg.sv | 22 ++
 rtl/ratio_edge_det.sv | 32 +++
 rtl/ratio_clk_meter.sv | 152 +++++++++++++++
 tb/tb_ratio_clk_meter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ratio_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ratio_clk_pkg
// Brief    : Shared types and defaults for the ratio clock generator/monitor.
// Revision : 1.0 - initial release
// ============================================================================
package ratio_clk_pkg;

  // Measurement FSM states of the clock meter.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } meter_state_e;

  localparam int DEF_CNT_W    = 16;
  localparam int DEF_LOCK_CNT = 4;
  // Wide enough for any lock threshold in 1..15.
  localparam int MATCH_W      = 4;

endpackage : ratio_clk_pkg
`default_nettype wire

// File: rtl/ratio_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : ratio_edge_det
// Brief    : One-register rising-edge detector for a signal that is already
//            synchronous to clk_i.
// Revision : 1.0 - initial release
// ============================================================================
module ratio_edge_det (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;
  logic prev_d;

  // Next history value is simply the current input.
  always_comb begin
    prev_d = d_i;
  end

  // History register, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

  assign rise_o = d_i & ~prev_q;

endmodule : ratio_edge_det
`default_nettype wire

// File: rtl/ratio_clk_meter.sv
`default_nettype none
// ============================================================================
// Module   : ratio_clk_meter
// Brief    : Measures period and high time of a clk_i-domain divided clock,
//            compares the period with an expected value and reports lock
//            and stuck-input overflow.
// Revision : 1.0 - initial release
// ============================================================================
module ratio_clk_meter
  import ratio_clk_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int LOCK_CNT = DEF_LOCK_CNT
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             en_i,
  input  logic             ratio_clk_i,
  input  logic [CNT_W-1:0] exp_period_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             locked_o,
  output logic             ovf_o
);

  localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]   CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);

  meter_state_e       state_q, state_d;
  logic [CNT_W-1:0]   period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]   high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [MATCH_W-1:0] match_cnt_q, match_cnt_d;
  logic               valid_q, valid_d;
  logic               locked_q, locked_d;
  logic               ovf_q, ovf_d;
  logic               rise;

  ratio_edge_det u_edge (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (ratio_clk_i),
    .rise_o (rise)
  );

  // Next-state, counter, result and lock logic for the measurement FSM.
  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    match_cnt_d  = match_cnt_q;
    valid_d      = 1'b0;
    locked_d     = locked_q;
    ovf_d        = ovf_q;

    if (!en_i) begin
      // Disable discards any in-flight measurement; results are held.
      state_d      = ST_IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      match_cnt_d  = '0;
      locked_d     = 1'b0;
      ovf_d        = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d      = ST_ARM;
          period_cnt_d = '0;
          high_cnt_d   = '0;
          match_cnt_d  = '0;
          locked_d     = 1'b0;
          ovf_d        = 1'b0;
        end
        ST_ARM: begin
          // The arming rise opens a measurement window but reports nothing.
          if (rise) begin
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
            state_d      = ST_MEAS;
          end
        end
        ST_MEAS: begin
          if (rise) begin
            period_d     = period_cnt_q;
            high_d       = high_cnt_q;
            valid_d      = 1'b1;
            ovf_d        = 1'b0;
            period_cnt_d = CNT_ONE;
            high_cnt_d   = CNT_ONE;
            // A zero expected period can never equal a real measurement.
            if ((period_cnt_q == exp_period_i) && (exp_period_i != '0)) begin
              if (match_cnt_q != LOCK_TGT) match_cnt_d = match_cnt_q + 1'b1;
            end else begin
              match_cnt_d = '0;
            end
            locked_d = (match_cnt_d == LOCK_TGT);
          end else if (period_cnt_q == CNT_MAX) begin
            // Input stuck or slower than the counter range: re-arm.
            ovf_d        = 1'b1;
            locked_d     = 1'b0;
            match_cnt_d  = '0;
            period_cnt_d = '0;
            high_cnt_d   = '0;
            state_d      = ST_ARM;
          end else begin
            period_cnt_d = period_cnt_q + CNT_ONE;
            high_cnt_d   = high_cnt_q + CNT_W'(ratio_clk_i);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and result registers with asynchronous clear.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= ST_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      match_cnt_q  <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      match_cnt_q  <= match_cnt_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      ovf_q        <= ovf_d;
    end
  end

  assign period_o = period_q;
  assign high_o   = high_q;
  assign valid_o  = valid_q;
  assign locked_o = locked_q;
  assign ovf_o    = ovf_q;

endmodule : ratio_clk_meter
`default_nettype wire

// File: tb/tb_ratio_clk_meter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ratio_clk_meter
// Brief    : Self-checking bench for ratio_clk_meter with a window-based
//            reference model of rise-to-rise measurements.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ratio_clk_meter;

  localparam int CW  = 8;
  localparam int LC  = 4;
  localparam int MAXP = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          arst;
  logic          en;
  logic          rclk;
  logic [CW-1:0] exp_p;
  logic [CW-1:0] period_o;
  logic [CW-1:0] high_o;
  logic          valid_o;
  logic          locked_o;
  logic          ovf_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: samples seen since the last accepted rise.
  bit m_prev, m_en_prev, m_armed;
  bit win[$];
  int m_period, m_high, m_mcnt;
  bit m_valid, m_locked, m_ovf;

  ratio_clk_meter #(.CNT_W(CW), .LOCK_CNT(LC)) dut (
    .clk_i        (clk),
    .arst_i       (arst),
    .en_i         (en),
    .ratio_clk_i  (rclk),
    .exp_period_i (exp_p),
    .period_o     (period_o),
    .high_o       (high_o),
    .valid_o      (valid_o),
    .locked_o     (locked_o),
    .ovf_o        (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int expv);
    n_cmp++;
    if (obs != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_prev = 0; m_en_prev = 0; m_armed = 0; win.delete();
    m_period = 0; m_high = 0; m_mcnt = 0;
    m_valid = 0; m_locked = 0; m_ovf = 0;
  endfunction

  // One clk_i cycle of the specified behaviour, using the inputs applied now.
  function automatic void model_update();
    bit rise;
    int hs;
    rise    = rclk && !m_prev;
    m_valid = 0;
    if (!en) begin
      m_armed = 0; win.delete(); m_mcnt = 0; m_locked = 0; m_ovf = 0;
    end else if (m_en_prev) begin
      if (rise) begin
        if (m_armed) begin
          hs = 0;
          foreach (win[i]) hs += int'(win[i]);
          m_period = win.size();
          m_high   = hs;
          m_valid  = 1;
          m_ovf    = 0;
          if (win.size() == int'(exp_p) && exp_p != 0)
            m_mcnt = (m_mcnt < LC) ? m_mcnt + 1 : LC;
          else
            m_mcnt = 0;
          m_locked = (m_mcnt == LC);
        end
        m_armed = 1;
        win.delete();
        win.push_back(1'b1);
      end else if (m_armed) begin
        if (win.size() == MAXP) begin
          m_ovf = 1; m_locked = 0; m_mcnt = 0; m_armed = 0; win.delete();
        end else begin
          win.push_back(rclk);
        end
      end
    end
    m_prev    = rclk;
    m_en_prev = en;
  endfunction

  task automatic compare_all();
    check("valid",  int'(valid_o),  int'(m_valid));
    check("period", int'(period_o), m_period);
    check("high",   int'(high_o),   m_high);
    check("locked", int'(locked_o), int'(m_locked));
    check("ovf",    int'(ovf_o),    int'(m_ovf));
  endtask

  task automatic drive(input bit r);
    rclk = r;
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic wave(input int hi, input int lo, input int nper);
    for (int p = 0; p < nper; p++) begin
      repeat (hi) drive(1'b1);
      repeat (lo) drive(1'b0);
    end
  endtask

  initial begin
    int hi, lo;
    arst = 1'b1; en = 1'b0; rclk = 1'b0; exp_p = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    check("rst_valid", int'(valid_o), 0);
    @(negedge clk);
    arst = 1'b0;

    // Steady 3 high / 5 low, expected period 8.
    exp_p = 8'd8; en = 1'b1;
    wave(3, 5, 8);
    check("steady_locked", int'(locked_o), 1);

    // Period change, then re-program the expected period.
    wave(3, 3, 2);
    exp_p = 8'd6;
    wave(3, 3, 6);
    check("relock", int'(locked_o), 1);

    // Enable drop mid-period while locked, then re-enable.
    drive(1'b1); drive(1'b1);
    en = 1'b0;
    drive(1'b0); drive(1'b0);
    check("drop_unlock", int'(locked_o), 0);
    en = 1'b1;
    wave(3, 3, 7);

    // Stuck-low input after an arming rise.
    drive(1'b1);
    repeat (300) drive(1'b0);
    wave(2, 4, 4);

    // Maximum rate toggling.
    exp_p = 8'd2;
    wave(1, 1, 10);
    check("maxrate_locked", int'(locked_o), 1);

    // Randomized segments with occasional enable glitches.
    for (int s = 0; s < 30; s++) begin
      hi = $urandom_range(1, 7);
      lo = $urandom_range(1, 7);
      case ($urandom_range(0, 3))
        0:       exp_p = CW'(hi + lo + 1);
        1:       exp_p = '0;
        default: exp_p = CW'(hi + lo);
      endcase
      if ($urandom_range(0, 5) == 0) begin
        en = 1'b0;
        repeat ($urandom_range(1, 3)) drive(1'($urandom_range(0, 1)));
        en = 1'b1;
      end
      wave(hi, lo, $urandom_range(3, 7));
    end

    // Asynchronous reset between edges while locked.
    exp_p = 8'd4;
    wave(2, 2, 7);
    check("pre_arst_locked", int'(locked_o), 1);
    #2;
    arst = 1'b1;
    #1;
    model_reset();
    compare_all();
    repeat (2) @(posedge clk);
    #3;
    arst = 1'b0;
    wave(2, 2, 7);
    check("post_arst_locked", int'(locked_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_ratio_clk_meter
`default_nettype wire
